// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that shares one memory port and feeds decode via valid/ready.
// Define FETCH_STATS_EN to add the o_stall_cnt / o_flush_cnt statistics ports.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_data,
  output logic        o_valid,
  output logic [15:0] o_ir,
  output logic [31:0] o_pc,
`ifdef FETCH_STATS_EN
  input  logic        i_ready,
  output logic [31:0] o_stall_cnt,
  output logic [15:0] o_flush_cnt
`else
  input  logic        i_ready
`endif
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW+1:0] L_DEPTH  = (AW+2)'(DEPTH);
  localparam logic [31:0] L_START_PC = RESET_PC & 32'hFFFF_FFFE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fetchPc;
  logic [31:0]   r_memAddr;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_memCount;
  logic          r_valid;
  logic [15:0]   r_ir;
  logic [31:0]   r_pc;
  logic [47:0]   r_mem [DEPTH];

  logic          w_pop;
  logic          w_push;
  logic          w_advance;
  logic [AW+1:0] w_total;
  logic [AW+1:0] w_totalNext;
  logic          w_space;
  logic [1:0]    w_stateNext;
  logic [31:0]   w_fetchPcNext;
  logic [31:0]   w_redirectPc;
  logic [47:0]   w_head;

  assign w_redirectPc = i_redirect_pc & 32'hFFFF_FFFE;
  assign w_pop        = r_valid & i_ready;
  assign w_push       = (r_state == S_REQ) & i_mem_ack & ~i_redirect;
  // The output register is the visible head; it refills from storage when empty or consumed.
  assign w_advance    = ~i_redirect & (r_memCount != '0) & (~r_valid | w_pop);
  assign w_head       = r_mem[r_rdPtr];

  always_comb begin
    w_total = {1'b0, r_memCount} + {{(AW+1){1'b0}}, r_valid};
    if (i_redirect) begin
      w_totalNext = '0;
    end else begin
      w_totalNext = w_total - {{(AW+1){1'b0}}, w_pop} + {{(AW+1){1'b0}}, w_push};
    end
    w_space = (w_totalNext < L_DEPTH);
  end

  always_comb begin
    w_fetchPcNext = r_fetchPc;
    if (i_redirect) begin
      w_fetchPcNext = w_redirectPc;
    end else if (w_push) begin
      w_fetchPcNext = r_fetchPc + 32'd2;
    end
  end

  // FLUSH keeps the abandoned request alive until memory acknowledges it.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        w_stateNext = w_space ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        if (i_mem_ack) begin
          w_stateNext = (i_redirect || !w_space) ? S_IDLE : S_REQ;
        end else begin
          w_stateNext = i_redirect ? S_FLUSH : S_REQ;
        end
      end
      S_FLUSH: begin
        if (i_mem_ack) begin
          w_stateNext = w_space ? S_REQ : S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_fetchPc  <= L_START_PC;
      r_memAddr  <= L_START_PC;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_memCount <= '0;
      r_valid    <= 1'b0;
      r_ir       <= '0;
      r_pc       <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_fetchPc <= w_fetchPcNext;
      if (w_stateNext == S_REQ) begin
        r_memAddr <= w_fetchPcNext;
      end

      if (i_redirect) begin
        r_wrPtr    <= '0;
        r_rdPtr    <= '0;
        r_memCount <= '0;
        r_valid    <= 1'b0;
      end else begin
        if (w_push) begin
          r_wrPtr <= r_wrPtr + AW'(1);
        end
        if (w_advance) begin
          r_rdPtr <= r_rdPtr + AW'(1);
        end
        r_memCount <= r_memCount + (AW+1)'(w_push) - (AW+1)'(w_advance);
        if (w_advance) begin
          r_valid <= 1'b1;
          r_pc    <= w_head[47:16];
          r_ir    <= w_head[15:0];
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {r_fetchPc, i_mem_data};
    end
  end

  assign o_mem_req  = (r_state != S_IDLE);
  assign o_mem_addr = r_memAddr;
  assign o_valid    = r_valid;
  assign o_ir       = r_ir;
  assign o_pc       = r_pc;

`ifdef FETCH_STATS_EN
  logic [31:0] r_stallCnt;
  logic [15:0] r_flushCnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (i_ready && !r_valid && !i_redirect && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (i_redirect && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + 16'd1;
      end
    end
  end

  assign o_stall_cnt = r_stallCnt;
  assign o_flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a program-order scoreboard.
// Stats checks are compiled in when FETCH_STATS_EN is defined.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic        o_valid;
  logic [15:0] o_ir;
  logic [31:0] o_pc;
  logic        i_ready;
`ifdef FETCH_STATS_EN
  logic [31:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_data    (i_mem_data),
    .o_valid       (o_valid),
    .o_ir          (o_ir),
    .o_pc          (o_pc),
`ifdef FETCH_STATS_EN
    .i_ready       (i_ready),
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
`else
    .i_ready       (i_ready)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Memory contents are a fixed function of the address so any read can be predicted.
  function automatic logic [15:0] memWord(input logic [31:0] a);
    return a[15:0] ^ a[31:16];
  endfunction

  assign i_mem_data = memWord(o_mem_addr);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic ready, input logic redirect, input logic [31:0] tgt);
    i_mem_ack     = ack;
    i_ready       = ready;
    i_redirect    = redirect;
    i_redirect_pc = tgt;
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    i_rst = 1'b0;
    #2;
    checkOutput("reset_state", {o_mem_req, o_mem_addr, o_valid, o_ir, o_pc},
                {1'b0, 32'h0, 1'b0, 16'h0, 32'h0});
`ifdef FETCH_STATS_EN
    checkOutput("reset_stats", {o_stall_cnt, o_flush_cnt}, 48'h0);
`endif
    tick;
    i_rst = 1'b1;
  endtask

  int          reqCycles;
  int          occ;
  int          popCnt;
  logic [31:0] expPc;
  logic [31:0] fetchExp;
  logic [31:0] prevAddr;
  logic [31:0] stallExp;
  logic [15:0] flushExp;
  logic        tainted;
  logic        prevRedirect;
  logic        prevHold;
  logic        rAck;
  logic        rReady;
  logic        rRed;
  logic [31:0] rTgt;

  initial begin
    // Streaming with a zero-wait memory.
    doReset;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("t1_first_req", {o_mem_req, o_mem_addr}, {1'b1, 32'h0});
    tick;
    checkOutput("t1_latency", o_valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick;
      checkOutput("t1_stream", {o_valid, o_pc, o_ir}, {1'b1, 32'(2 * k), 16'(2 * k)});
    end

    // Decode stalled: queue fills to DEPTH, then drains in order.
    doReset;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    reqCycles = 0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (o_mem_req) reqCycles++;
    end
    checkOutput("t2_push_count", reqCycles, DEPTH);
    checkOutput("t2_full_idle", {o_mem_req, o_valid, o_pc}, {1'b0, 1'b1, 32'h0});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t2_drain", {o_valid, o_pc, o_ir}, {1'b1, 32'(2 * k), 16'(2 * k)});
      tick;
    end

    // Slow memory: request held stable for three cycles.
    doReset;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick;
      checkOutput("t3_hold", {o_mem_req, o_mem_addr, o_valid}, {1'b1, 32'h0, 1'b0});
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t3_next_addr", {o_mem_req, o_mem_addr, o_valid}, {1'b1, 32'h2, 1'b0});
    tick;
    checkOutput("t3_single", {o_valid, o_pc, o_ir}, {1'b1, 32'h0, 16'h0});
    tick;
    checkOutput("t3_one_push", {o_valid, o_mem_req, o_mem_addr}, {1'b0, 1'b1, 32'h2});

    // Redirect while a request is pending without ack.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0101);
    tick;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("t4_flush_hold", {o_mem_req, o_mem_addr, o_valid}, {1'b1, 32'h2, 1'b0});
    tick;
    checkOutput("t4_flush_wait", {o_mem_req, o_mem_addr, o_valid}, {1'b1, 32'h2, 1'b0});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("t4_new_addr", {o_mem_req, o_mem_addr, o_valid}, {1'b1, 32'h100, 1'b0});
    tick;
    checkOutput("t4_no_stale", o_valid, 1'b0);
    tick;
    checkOutput("t4_target", {o_valid, o_pc, o_ir}, {1'b1, 32'h100, 16'h100});

    // Redirect colliding with ack and pop on a loaded queue.
    doReset;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) tick;
    checkOutput("t5_full", {o_mem_req, o_valid, o_pc}, {1'b0, 1'b1, 32'h0});
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    checkOutput("t5_refill", {o_valid, o_pc, o_mem_req, o_mem_addr}, {1'b1, 32'h2, 1'b1, 32'h8});
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    tick;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("t5_flushed", {o_valid, o_mem_req}, {1'b0, 1'b0});
    tick;
    checkOutput("t5_target_req", {o_valid, o_mem_req, o_mem_addr}, {1'b0, 1'b1, 32'h200});
    tick;
    checkOutput("t5_no_stale", o_valid, 1'b0);
    tick;
    checkOutput("t5_target", {o_valid, o_pc, o_ir}, {1'b1, 32'h200, 16'h200});

`ifdef FETCH_STATS_EN
    // Statistics: five starved cycles, two redirects, then async reset.
    doReset;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (5) tick;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    repeat (2) tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("t6_stall", o_stall_cnt, 32'd5);
    checkOutput("t6_flush", o_flush_cnt, 16'd2);
    i_rst = 1'b0;
    #2;
    checkOutput("t6_reset", {o_stall_cnt, o_flush_cnt}, 48'h0);
    tick;
    i_rst = 1'b1;
`endif

    // Random traffic against a program-order scoreboard.
    doReset;
    expPc        = 32'h0;
    fetchExp     = 32'h0;
    occ          = 0;
    popCnt       = 0;
    tainted      = 1'b0;
    prevRedirect = 1'b0;
    prevHold     = 1'b0;
    prevAddr     = 32'h0;
    stallExp     = 32'h0;
    flushExp     = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      rReady = ($urandom_range(0, 9) < 7);
      rRed   = ($urandom_range(0, 29) == 0);
      rTgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rAck   = o_mem_req && ($urandom_range(0, 3) != 0);
      applyStimulus(rAck, rReady, rRed, rTgt);

`ifdef FETCH_STATS_EN
      checkOutput("rnd_stall_cnt", o_stall_cnt, stallExp);
      checkOutput("rnd_flush_cnt", o_flush_cnt, flushExp);
      if (rReady && !o_valid && !rRed) stallExp++;
      if (rRed) flushExp++;
`endif
      if (prevRedirect) checkOutput("rnd_valid_after_redirect", o_valid, 1'b0);
      if (prevHold) checkOutput("rnd_req_stable", {o_mem_req, o_mem_addr}, {1'b1, prevAddr});
      checkOutput("rnd_phantom_valid", (o_valid && occ == 0), 1'b0);

      if (o_valid && rReady && !rRed) begin
        checkOutput("rnd_pop", {o_pc, o_ir}, {expPc, memWord(expPc)});
        expPc += 32'd2;
        popCnt++;
        occ--;
      end
      if (o_mem_req && rAck) begin
        if (!rRed && !tainted) begin
          checkOutput("rnd_fetch_addr", o_mem_addr, fetchExp);
          fetchExp += 32'd2;
          occ++;
          checkOutput("rnd_occupancy", (occ <= DEPTH), 1'b1);
        end
        tainted = 1'b0;
      end else if (o_mem_req && rRed) begin
        tainted = 1'b1;
      end
      if (rRed) begin
        occ      = 0;
        expPc    = rTgt & 32'hFFFF_FFFE;
        fetchExp = rTgt & 32'hFFFF_FFFE;
      end

      prevRedirect = rRed;
      prevHold     = o_mem_req && !rAck;
      prevAddr     = o_mem_addr;
      tick;
    end
    checkOutput("rnd_progress", (popCnt > 200), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
